hazard_ctrl: RTL and testbench

- Pipeline control unit for the 5-stage core. It drives the enable and flush inputs of the PC, IF/ID, ID/EX and EX/MEM registers.
- Resolves three conditions:
  - load-use hazards, with a one-bubble stall;
  - taken branch/jump redirects, with a flush plus optional extra fetch-latency flushes;
  - data-memory wait states, with a full pipeline freeze plus a timeout watchdog.
- Maintains saturating stall and flush event counters for performance debug.

---
 rtl/hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_hazard_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, redirect flush, data-memory freeze
// with timeout watchdog, plus saturating stall/flush event counters.
module hazard_ctrl #(
    parameter int REDIRECT_CYCLES = 1,
    parameter int MEM_TIMEOUT     = 64,
    parameter int CNT_W           = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [4:0]       dec_addr1,
    input  logic [4:0]       dec_addr2,
    input  logic             dec_use1,
    input  logic             dec_use2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_Rmem,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT);
    localparam logic [WCNT_W-1:0] WCNT_LIM = WCNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {RUN, REDIRECT, MEM_WAIT} state_t;

    state_t            state;
    state_t            saved_state;
    state_t            cur_state;
    logic [3:0]        rcnt;
    logic [WCNT_W-1:0] wcnt;
    logic              freeze;
    logic              load_use;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // While frozen the pipeline behaves as if still in the pre-freeze state.
    always_comb begin
        cur_state = (state == MEM_WAIT) ? saved_state : state;
        freeze    = mem_req && !mem_ready;
        load_use  = ex_Rmem && (ex_rd != 5'd0) &&
                    ((dec_use1 && (dec_addr1 == ex_rd)) ||
                     (dec_use2 && (dec_addr2 == ex_rd)));
    end

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (Reset) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (freeze) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
        end else if (cur_state == REDIRECT) begin
            ifid_flush = 1'b1;
        end else if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= RUN;
            saved_state <= RUN;
            rcnt        <= 4'd0;
            wcnt        <= '0;
            mem_timeout <= 1'b0;
            stall_count <= '0;
            flush_count <= '0;
        end else if (freeze) begin
            if (state != MEM_WAIT)
                saved_state <= state;
            state       <= MEM_WAIT;
            stall_count <= sat_inc(stall_count);
            if (wcnt != WCNT_LIM)
                wcnt <= wcnt + 1'b1;
            else
                mem_timeout <= 1'b1;
        end else begin
            wcnt <= '0;
            if (cur_state == REDIRECT) begin
                if (rcnt == 4'd0) begin
                    state <= RUN;
                end else begin
                    state <= REDIRECT;
                    rcnt  <= rcnt - 4'd1;
                end
            end else begin
                state <= RUN;
                if (ex_redirect) begin
                    flush_count <= sat_inc(flush_count);
                    if (REDIRECT_CYCLES > 0) begin
                        state <= REDIRECT;
                        rcnt  <= 4'(REDIRECT_CYCLES - 1);
                    end
                end else if (load_use) begin
                    stall_count <= sat_inc(stall_count);
                end
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table for single-cycle hazard decode,
// hand-written sequences for redirect, freeze, timeout and reset corners.
module tb_hazard_ctrl;

    localparam int CNT_W = 16;

    logic             Clock = 1'b0;
    logic             Reset;
    logic [4:0]       dec_addr1, dec_addr2, ex_rd;
    logic             dec_use1, dec_use2, ex_Rmem, ex_redirect, mem_req, mem_ready;
    logic             pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_count, flush_count;
    logic [5:0]       outs;

    int errors = 0;
    int checks = 0;

    // {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush}
    localparam logic [5:0] O_DEF   = 6'b111100;
    localparam logic [5:0] O_STALL = 6'b001101;
    localparam logic [5:0] O_REDIR = 6'b111111;
    localparam logic [5:0] O_RFL   = 6'b111110;
    localparam logic [5:0] O_FRZ   = 6'b000000;
    localparam logic [5:0] O_RST   = 6'b000011;

    hazard_ctrl #(
        .REDIRECT_CYCLES(2),
        .MEM_TIMEOUT    (8),
        .CNT_W          (CNT_W)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .dec_addr1  (dec_addr1),
        .dec_addr2  (dec_addr2),
        .dec_use1   (dec_use1),
        .dec_use2   (dec_use2),
        .ex_rd      (ex_rd),
        .ex_Rmem    (ex_Rmem),
        .ex_redirect(ex_redirect),
        .mem_req    (mem_req),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .ifid_en    (ifid_en),
        .idex_en    (idex_en),
        .exmem_en   (exmem_en),
        .ifid_flush (ifid_flush),
        .idex_flush (idex_flush),
        .mem_timeout(mem_timeout),
        .stall_count(stall_count),
        .flush_count(flush_count)
    );

    always #5 Clock = ~Clock;

    assign outs = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush};

    typedef struct {
        string      name;
        logic [4:0] a1;
        logic [4:0] a2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       rmem;
        logic       req;
        logic       rdy;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        dec_addr1 = 5'd0; dec_addr2 = 5'd0; dec_use1 = 1'b0; dec_use2 = 1'b0;
        ex_rd = 5'd0; ex_Rmem = 1'b0; ex_redirect = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    // Inputs are set just after an edge; outputs are sampled mid-cycle.
    task automatic step(input string nm, input logic [5:0] exp);
        #4;
        chk(nm, {26'd0, outs}, {26'd0, exp});
        @(posedge Clock);
        #1;
    endtask

    initial begin
        tbl[0] = '{"lu_rs1",      5'd5,  5'd0,  1, 0, 5'd5,  1, 0, 0, O_STALL};
        tbl[1] = '{"after_lu",    5'd5,  5'd0,  1, 0, 5'd5,  0, 0, 0, O_DEF};
        tbl[2] = '{"lu_x0",       5'd0,  5'd0,  1, 1, 5'd0,  1, 0, 0, O_DEF};
        tbl[3] = '{"lu_rs2",      5'd1,  5'd7,  0, 1, 5'd7,  1, 0, 0, O_STALL};
        tbl[4] = '{"no_use",      5'd9,  5'd9,  0, 0, 5'd9,  1, 0, 0, O_DEF};
        tbl[5] = '{"no_match",    5'd3,  5'd2,  1, 1, 5'd4,  1, 0, 0, O_DEF};
        tbl[6] = '{"lu_rs2_31",   5'd1,  5'd31, 1, 1, 5'd31, 1, 0, 0, O_STALL};
        tbl[7] = '{"lu_memready", 5'd6,  5'd0,  1, 0, 5'd6,  1, 1, 1, O_STALL};
        tbl[8] = '{"memready",    5'd6,  5'd0,  1, 0, 5'd6,  0, 1, 1, O_DEF};
        tbl[9] = '{"lu_rs2_x0",   5'd0,  5'd0,  0, 1, 5'd0,  1, 0, 0, O_DEF};

        idle();
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        step("rst_outs", O_RST);
        chk("rst_stall", 32'(stall_count), 32'd0);
        chk("rst_flush", 32'(flush_count), 32'd0);
        chk("rst_tmo", {31'd0, mem_timeout}, 32'd0);
        Reset = 1'b0;
        step("idle", O_DEF);

        for (int i = 0; i < 10; i++) begin
            dec_addr1 = tbl[i].a1; dec_addr2 = tbl[i].a2;
            dec_use1  = tbl[i].u1; dec_use2  = tbl[i].u2;
            ex_rd     = tbl[i].rd; ex_Rmem   = tbl[i].rmem;
            mem_req   = tbl[i].req; mem_ready = tbl[i].rdy;
            ex_redirect = 1'b0;
            step(tbl[i].name, tbl[i].exp);
        end
        idle();
        chk("tbl_stall", 32'(stall_count), 32'd4);
        chk("tbl_flush", 32'(flush_count), 32'd0);

        // Redirect with two follow-up flush cycles; redirect/load-use ignored meanwhile.
        ex_redirect = 1'b1;
        step("redir_c0", O_REDIR);
        dec_use1 = 1'b1; dec_addr1 = 5'd8; ex_rd = 5'd8; ex_Rmem = 1'b1;
        step("redir_c1", O_RFL);
        idle();
        step("redir_c2", O_RFL);
        step("redir_c3", O_DEF);
        chk("redir_flush", 32'(flush_count), 32'd1);
        chk("redir_stall", 32'(stall_count), 32'd4);

        // Four-cycle freeze.
        mem_req = 1'b1;
        for (int k = 0; k < 4; k++) step("frz", O_FRZ);
        mem_ready = 1'b1;
        step("frz_exit", O_DEF);
        idle();
        chk("frz_stall", 32'(stall_count), 32'd8);
        chk("frz_tmo", {31'd0, mem_timeout}, 32'd0);

        // Freeze together with a redirect: redirect is taken once, on the ready cycle.
        mem_req = 1'b1; ex_redirect = 1'b1;
        step("sim_frz0", O_FRZ);
        step("sim_frz1", O_FRZ);
        mem_ready = 1'b1;
        step("sim_redir", O_REDIR);
        idle();
        step("sim_rfl1", O_RFL);
        step("sim_rfl2", O_RFL);
        step("sim_done", O_DEF);
        chk("sim_flush", 32'(flush_count), 32'd2);
        chk("sim_stall", 32'(stall_count), 32'd10);

        // Freeze in the middle of REDIRECT holds the remaining flush count.
        ex_redirect = 1'b1;
        step("rf_redir", O_REDIR);
        ex_redirect = 1'b0; mem_req = 1'b1;
        step("rf_frz0", O_FRZ);
        step("rf_frz1", O_FRZ);
        mem_ready = 1'b1;
        step("rf_rfl1", O_RFL);
        idle();
        step("rf_rfl2", O_RFL);
        step("rf_done", O_DEF);
        chk("rf_flush", 32'(flush_count), 32'd3);
        chk("rf_stall", 32'(stall_count), 32'd12);

        // Watchdog: ten wait cycles, flag rises after the eighth and is sticky.
        mem_req = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step("tmo_frz", O_FRZ);
            chk($sformatf("tmo_flag_%0d", k), {31'd0, mem_timeout}, (k >= 8) ? 32'd1 : 32'd0);
        end
        mem_ready = 1'b1;
        step("tmo_exit", O_DEF);
        idle();
        step("tmo_idle", O_DEF);
        chk("tmo_sticky", {31'd0, mem_timeout}, 32'd1);
        chk("tmo_stall", 32'(stall_count), 32'd22);

        // Reset while in REDIRECT with rcnt=1.
        ex_redirect = 1'b1;
        step("mr_redir", O_REDIR);
        idle();
        Reset = 1'b1;
        step("mr_rst0", O_RST);
        chk("mr_stall", 32'(stall_count), 32'd0);
        chk("mr_flush", 32'(flush_count), 32'd0);
        chk("mr_tmo", {31'd0, mem_timeout}, 32'd0);
        step("mr_rst1", O_RST);
        Reset = 1'b0;
        step("mr_run", O_DEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
